soc_addr_map_cfg: RTL

- Runtime-programmable successor to the static SoC address map.
- Holds `NumRules` rules of the form {idx, start_addr, end_addr, en}.
- Rules are programmed through a simple register request port into a shadow table, then atomically committed to an active table.
- Sits beside the crossbar and answers pipelined address lookups with a slave index, hit flag or decode error; a sticky lock freezes the map after boot.

---
 rtl/soc_addr_map_cfg.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/soc_addr_map_cfg.sv
// Runtime-programmable SoC address map: shadow/active rule tables behind a register
// port, atomic validated commit, sticky lock and a one-stage lookup pipeline.
module soc_addr_map_cfg #(
   parameter int unsigned NumRules   = 16,
   parameter int unsigned AddrWidth  = 64,
   parameter int unsigned IdxWidth   = 5,
   parameter bit          DefaultEn  = 1'b1,
   parameter int unsigned DefaultIdx = 0,
   localparam int unsigned CfgAddrWidth = $clog2(NumRules) + 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cfg_req_i,
   input  logic                    cfg_we_i,
   input  logic [CfgAddrWidth-1:0] cfg_addr_i,
   input  logic [AddrWidth-1:0]    cfg_wdata_i,
   output logic                    cfg_gnt_o,
   output logic                    cfg_rvalid_o,
   output logic [AddrWidth-1:0]    cfg_rdata_o,
   output logic                    cfg_err_o,
   input  logic                    commit_i,
   output logic                    commit_err_o,
   input  logic                    lock_i,
   output logic                    locked_o,
   input  logic                    lk_valid_i,
   output logic                    lk_ready_o,
   input  logic [AddrWidth-1:0]    lk_addr_i,
   output logic                    res_valid_o,
   input  logic                    res_ready_i,
   output logic [IdxWidth-1:0]     res_idx_o,
   output logic                    res_hit_o,
   output logic                    res_err_o
);

   localparam int unsigned RuleW = (NumRules > 1) ? $clog2(NumRules) : 1;
   localparam logic [CfgAddrWidth-1:0] NrLimit = CfgAddrWidth'(NumRules);

   logic [AddrWidth-1:0] sh_start [NumRules];
   logic [AddrWidth-1:0] sh_end   [NumRules];
   logic                 sh_en    [NumRules];
   logic [IdxWidth-1:0]  sh_idx   [NumRules];
   logic [AddrWidth-1:0] act_start [NumRules];
   logic [AddrWidth-1:0] act_end   [NumRules];
   logic                 act_en    [NumRules];
   logic [IdxWidth-1:0]  act_idx   [NumRules];

   logic                    locked_q;
   logic [CfgAddrWidth-1:0] cfg_rule_full;
   logic [RuleW-1:0]        cfg_ridx;
   logic [1:0]              cfg_field;
   logic                    cfg_bad;
   logic                    cfg_wr_ok;
   logic [AddrWidth-1:0]    rd_val;
   logic                    shadow_bad;
   logic                    commit_ok;
   logic                    lk_hit;
   logic [IdxWidth-1:0]     lk_idx;
   logic                    lk_fire;

   logic                    cfg_rvalid_p1;
   logic                    cfg_err_p1;
   logic [AddrWidth-1:0]    cfg_rdata_p1;
   logic                    commit_err_p1;
   logic                    vld_p1;
   logic [IdxWidth-1:0]     idx_p1;
   logic                    hit_p1;
   logic                    err_p1;

   function automatic logic rule_match(input logic en, input logic [AddrWidth-1:0] lo,
                                       input logic [AddrWidth-1:0] hi,
                                       input logic [AddrWidth-1:0] addr);
      return en && (addr >= lo) && (addr < hi);
   endfunction

   assign cfg_rule_full = cfg_addr_i >> 2;
   assign cfg_ridx      = cfg_rule_full[RuleW-1:0];
   assign cfg_field     = cfg_addr_i[1:0];
   assign cfg_bad       = (cfg_rule_full >= NrLimit) || (cfg_field == 2'd3) ||
                          (cfg_we_i && locked_q);
   assign cfg_wr_ok     = cfg_req_i && cfg_we_i && !cfg_bad;
   assign cfg_gnt_o     = cfg_req_i;

   always_comb begin
      rd_val = '0;
      case (cfg_field)
         2'd0:    rd_val = sh_start[cfg_ridx];
         2'd1:    rd_val = sh_end[cfg_ridx];
         2'd2:    rd_val = AddrWidth'({sh_en[cfg_ridx], sh_idx[cfg_ridx]});
         default: rd_val = '0;
      endcase
   end

   // A single malformed enabled rule poisons the whole commit.
   always_comb begin
      shadow_bad = 1'b0;
      for (int i = 0; i < int'(NumRules); i++) begin
         if (sh_en[i] && (sh_end[i] <= sh_start[i])) shadow_bad = 1'b1;
      end
   end

   assign commit_ok = commit_i && !locked_q && !shadow_bad;

   // Ascending scan so the highest-numbered matching rule overrides lower ones.
   always_comb begin
      lk_hit = 1'b0;
      lk_idx = '0;
      for (int i = 0; i < int'(NumRules); i++) begin
         if (rule_match(act_en[i], act_start[i], act_end[i], lk_addr_i)) begin
            lk_hit = 1'b1;
            lk_idx = act_idx[i];
         end
      end
   end

   assign lk_ready_o = !vld_p1 || res_ready_i;
   assign lk_fire    = lk_valid_i && lk_ready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(NumRules); i++) begin
            sh_start[i]  <= '0;
            sh_end[i]    <= '0;
            sh_en[i]     <= 1'b0;
            sh_idx[i]    <= '0;
            act_start[i] <= '0;
            act_end[i]   <= '0;
            act_en[i]    <= 1'b0;
            act_idx[i]   <= '0;
         end
      end else begin
         if (cfg_wr_ok) begin
            case (cfg_field)
               2'd0: sh_start[cfg_ridx] <= cfg_wdata_i;
               2'd1: sh_end[cfg_ridx]   <= cfg_wdata_i;
               2'd2: begin
                  sh_en[cfg_ridx]  <= cfg_wdata_i[IdxWidth];
                  sh_idx[cfg_ridx] <= cfg_wdata_i[IdxWidth-1:0];
               end
               default: ;
            endcase
         end
         // Active copy samples the pre-edge shadow, so a same-cycle write is excluded.
         if (commit_ok) begin
            for (int i = 0; i < int'(NumRules); i++) begin
               act_start[i] <= sh_start[i];
               act_end[i]   <= sh_end[i];
               act_en[i]    <= sh_en[i];
               act_idx[i]   <= sh_idx[i];
            end
         end
      end
   end

   // ---- stage p1: registered cfg response, commit status and lookup result ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         locked_q      <= 1'b0;
         cfg_rvalid_p1 <= 1'b0;
         cfg_err_p1    <= 1'b0;
         cfg_rdata_p1  <= '0;
         commit_err_p1 <= 1'b0;
         vld_p1        <= 1'b0;
         idx_p1        <= '0;
         hit_p1        <= 1'b0;
         err_p1        <= 1'b0;
      end else begin
         locked_q      <= locked_q | lock_i;
         cfg_rvalid_p1 <= cfg_req_i;
         cfg_err_p1    <= cfg_req_i && cfg_bad;
         cfg_rdata_p1  <= (cfg_req_i && !cfg_we_i && !cfg_bad) ? rd_val : '0;
         commit_err_p1 <= commit_i && !locked_q && shadow_bad;
         if (lk_fire) begin
            vld_p1 <= 1'b1;
            hit_p1 <= lk_hit;
            err_p1 <= !lk_hit && !DefaultEn;
            idx_p1 <= lk_hit ? lk_idx : (DefaultEn ? IdxWidth'(DefaultIdx) : '0);
         end else if (res_ready_i) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign locked_o     = locked_q;
   assign cfg_rvalid_o = cfg_rvalid_p1;
   assign cfg_err_o    = cfg_err_p1;
   assign cfg_rdata_o  = cfg_rdata_p1;
   assign commit_err_o = commit_err_p1;
   assign res_valid_o  = vld_p1;
   assign res_idx_o    = idx_p1;
   assign res_hit_o    = hit_p1;
   assign res_err_o    = err_p1;

endmodule
